// File: rtl/tdc_pkg.sv
// Shared TDC chip-bus definitions: widths, register addresses, FSM states and result payload.
package tdc_pkg;

  localparam int unsigned TDC_DATA_W = 28;
  localparam int unsigned TDC_ADDR_W = 4;

  localparam logic [TDC_ADDR_W-1:0] TDC_ADDR_FIFO1 = 4'd8;
  localparam logic [TDC_ADDR_W-1:0] TDC_ADDR_FIFO2 = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_DISABLE,
    ST_POLL,
    ST_READ,
    ST_OUT,
    ST_DONE
  } tdc_state_e;

  typedef enum logic [1:0] {
    BR_IDLE,
    BR_SETUP,
    BR_STROBE,
    BR_HOLD
  } bus_rd_state_e;

  typedef struct packed {
    logic                  fifo;
    logic [TDC_DATA_W-1:0] data;
  } tdc_result_t;

endpackage

// File: rtl/tdc_bus_read.sv
// Single chip-bus register read: SETUP (CSN low), STROBE (RDN low, sample data), HOLD (bus idle, ack).
module tdc_bus_read
  import tdc_pkg::*;
#(
  parameter int unsigned           RD_SETUP = 1,
  parameter int unsigned           RD_LOW   = 2,
  parameter logic [TDC_ADDR_W-1:0] ADDR0    = TDC_ADDR_FIFO1,
  parameter logic [TDC_ADDR_W-1:0] ADDR1    = TDC_ADDR_FIFO2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  sel,
  input  logic [TDC_DATA_W-1:0] data_in,
  output logic                  CSN,
  output logic                  RDN,
  output logic [TDC_ADDR_W-1:0] addr,
  output logic [TDC_DATA_W-1:0] rdata,
  output logic                  ack
);

  localparam int unsigned CNT_MAX = (RD_SETUP > RD_LOW) ? RD_SETUP : RD_LOW;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  bus_rd_state_e         state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  csn_d, rdn_d, ack_d;
  logic [TDC_ADDR_W-1:0] addr_d;
  logic [TDC_DATA_W-1:0] rdata_d;

  // State, phase counter and registered bus outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= BR_IDLE;
      cnt   <= '0;
      CSN   <= 1'b1;
      RDN   <= 1'b1;
      addr  <= '0;
      rdata <= '0;
      ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      CSN   <= csn_d;
      RDN   <= rdn_d;
      addr  <= addr_d;
      rdata <= rdata_d;
      ack   <= ack_d;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      BR_IDLE: begin
        if (req) begin
          state_nxt = BR_SETUP;
          cnt_nxt   = '0;
        end
      end
      BR_SETUP: begin
        if (cnt == CNT_W'(RD_SETUP - 1)) begin
          state_nxt = BR_STROBE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      BR_STROBE: begin
        if (cnt == CNT_W'(RD_LOW - 1)) begin
          state_nxt = BR_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      BR_HOLD: state_nxt = BR_IDLE;
      default: state_nxt = BR_IDLE;
    endcase
  end

  // Outputs follow the next state so strobes line up with the state they belong to
  always_comb begin
    csn_d   = !((state_nxt == BR_SETUP) || (state_nxt == BR_STROBE));
    rdn_d   = (state_nxt != BR_STROBE);
    ack_d   = (state_nxt == BR_HOLD);
    addr_d  = addr;
    rdata_d = rdata;
    if ((state == BR_IDLE) && req) begin
      addr_d = sel ? ADDR1 : ADDR0;
    end
    if ((state == BR_STROBE) && (cnt == CNT_W'(RD_LOW - 1))) begin
      rdata_d = data_in;
    end
  end

endmodule

// File: rtl/tdc_readout_ctrl.sv
// One TDC measurement: arm stops for a window, disable, then drain FIFO1/FIFO2 to a valid/ready port.
module tdc_readout_ctrl
  import tdc_pkg::*;
#(
  parameter int unsigned           WINDOW_CYC = 1000,
  parameter int unsigned           RD_SETUP   = 1,
  parameter int unsigned           RD_LOW     = 2,
  parameter int unsigned           MAX_HITS   = 16,
  parameter logic [TDC_ADDR_W-1:0] ADDR_FIFO1 = TDC_ADDR_FIFO1,
  parameter logic [TDC_ADDR_W-1:0] ADDR_FIFO2 = TDC_ADDR_FIFO2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  init_done,
  input  logic                  start,
  input  logic                  EF1,
  input  logic                  EF2,
  input  logic [TDC_DATA_W-1:0] data_in,
  output logic                  CSN,
  output logic                  RDN,
  output logic [TDC_ADDR_W-1:0] addr,
  output logic [3:0]            StopDis,
  output logic [TDC_DATA_W-1:0] res_data,
  output logic                  res_fifo,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  hit_ovf
);

  localparam int unsigned WIN_W = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
  localparam int unsigned HIT_W = $clog2(MAX_HITS + 1);

  tdc_state_e            state, state_nxt;
  logic [WIN_W-1:0]      win_cnt, win_cnt_nxt;
  logic [HIT_W-1:0]      hit_cnt, hit_cnt_nxt;
  logic                  sel_q, sel_nxt;
  logic                  rd_req_c;
  logic                  rd_ack;
  logic [TDC_DATA_W-1:0] rd_data;

  tdc_result_t res_q, res_d;
  logic [3:0]  stopdis_d;
  logic        res_valid_d, busy_d, done_d, hit_ovf_d;

  wire go = start && init_done;

  tdc_bus_read #(
    .RD_SETUP (RD_SETUP),
    .RD_LOW   (RD_LOW),
    .ADDR0    (ADDR_FIFO1),
    .ADDR1    (ADDR_FIFO2)
  ) u_bus_read (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (rd_req_c),
    .sel     (sel_nxt),
    .data_in (data_in),
    .CSN     (CSN),
    .RDN     (RDN),
    .addr    (addr),
    .rdata   (rd_data),
    .ack     (rd_ack)
  );

  // State register and counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      win_cnt <= '0;
      hit_cnt <= '0;
      sel_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      win_cnt <= win_cnt_nxt;
      hit_cnt <= hit_cnt_nxt;
      sel_q   <= sel_nxt;
    end
  end

  // Next-state logic; EF flags only matter in POLL
  always_comb begin
    state_nxt   = state;
    win_cnt_nxt = win_cnt;
    hit_cnt_nxt = hit_cnt;
    sel_nxt     = sel_q;
    rd_req_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_nxt   = ST_ARM;
          win_cnt_nxt = '0;
          hit_cnt_nxt = '0;
        end
      end
      ST_ARM: begin
        if (win_cnt == WIN_W'(WINDOW_CYC - 1)) begin
          state_nxt   = ST_DISABLE;
          win_cnt_nxt = '0;
        end else begin
          win_cnt_nxt = win_cnt + WIN_W'(1);
        end
      end
      ST_DISABLE: state_nxt = ST_POLL;
      ST_POLL: begin
        if (!EF1) begin
          sel_nxt   = 1'b0;
          rd_req_c  = 1'b1;
          state_nxt = ST_READ;
        end else if (!EF2) begin
          sel_nxt   = 1'b1;
          rd_req_c  = 1'b1;
          state_nxt = ST_READ;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_READ: begin
        if (rd_ack) begin
          hit_cnt_nxt = hit_cnt + HIT_W'(1);
          state_nxt   = ST_OUT;
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          state_nxt = (hit_cnt == HIT_W'(MAX_HITS)) ? ST_DONE : ST_POLL;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic, registered below
  always_comb begin
    stopdis_d   = (state_nxt == ST_ARM) ? 4'b0000 : 4'b1111;
    busy_d      = (state_nxt != ST_IDLE);
    done_d      = (state_nxt == ST_DONE);
    res_valid_d = (state_nxt == ST_OUT);
    res_d       = res_q;
    hit_ovf_d   = hit_ovf;
    if ((state == ST_READ) && rd_ack) begin
      res_d.data = rd_data;
      res_d.fifo = sel_q;
    end
    if ((state == ST_IDLE) && go) begin
      hit_ovf_d = 1'b0;
    end
    if ((state == ST_OUT) && res_ready && (hit_cnt == HIT_W'(MAX_HITS))) begin
      hit_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      StopDis   <= 4'b1111;
      res_q     <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit_ovf   <= 1'b0;
    end else begin
      StopDis   <= stopdis_d;
      res_q     <= res_d;
      res_valid <= res_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      hit_ovf   <= hit_ovf_d;
    end
  end

  assign res_data = res_q.data;
  assign res_fifo = res_q.fifo;

endmodule

// File: tb/tb_tdc_readout_ctrl.sv
// Bench for tdc_readout_ctrl: chip FIFO model, bus-timing monitor and result scoreboard.
module tb_tdc_readout_ctrl;
  import tdc_pkg::*;

  localparam int WINDOW_CYC = 1000;
  localparam int RD_SETUP   = 1;
  localparam int RD_LOW     = 2;
  localparam int MAX_HITS   = 16;

  logic                  clk = 1'b0;
  logic                  reset_n, init_done, start, EF1, EF2, res_ready;
  logic [TDC_DATA_W-1:0] data_in;
  logic                  CSN, RDN, res_fifo, res_valid, busy, done, hit_ovf;
  logic [TDC_ADDR_W-1:0] addr;
  logic [3:0]            StopDis;
  logic [TDC_DATA_W-1:0] res_data;

  logic [TDC_DATA_W-1:0] chip1[$];
  logic [TDC_DATA_W-1:0] chip2[$];
  tdc_result_t           sb[$];
  logic [TDC_ADDR_W-1:0] last_rd_addr;

  int checks = 0;
  int errors = 0;
  int res_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  tdc_readout_ctrl #(
    .WINDOW_CYC (WINDOW_CYC),
    .RD_SETUP   (RD_SETUP),
    .RD_LOW     (RD_LOW),
    .MAX_HITS   (MAX_HITS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .init_done (init_done),
    .start     (start),
    .EF1       (EF1),
    .EF2       (EF2),
    .data_in   (data_in),
    .CSN       (CSN),
    .RDN       (RDN),
    .addr      (addr),
    .StopDis   (StopDis),
    .res_data  (res_data),
    .res_fifo  (res_fifo),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .done      (done),
    .hit_ovf   (hit_ovf)
  );

  // Chip model: FIFO head on data_in, pop on RDN rising edge
  initial begin : chip_model
    logic rdn_q;
    EF1 = 1'b1; EF2 = 1'b1; data_in = '0; rdn_q = 1'b1;
    forever begin
      @(negedge clk);
      if (!rdn_q && RDN && reset_n) begin
        if (addr == TDC_ADDR_FIFO1 && chip1.size() > 0) void'(chip1.pop_front());
        else if (addr == TDC_ADDR_FIFO2 && chip2.size() > 0) void'(chip2.pop_front());
      end
      rdn_q = RDN;
      EF1 = (chip1.size() == 0);
      EF2 = (chip2.size() == 0);
      if (addr == TDC_ADDR_FIFO1 && chip1.size() > 0) data_in = chip1[0];
      else if (addr == TDC_ADDR_FIFO2 && chip2.size() > 0) data_in = chip2[0];
      else data_in = '0;
    end
  end

  // Bus timing monitor and result scoreboard
  initial begin : monitor
    logic rdn_q, done_q;
    int csn_run, rdn_run;
    tdc_result_t e;
    logic [TDC_ADDR_W-1:0] ea;
    rdn_q = 1'b1; done_q = 1'b0; csn_run = 0; rdn_run = 0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        rdn_q = 1'b1; done_q = 1'b0; csn_run = 0; rdn_run = 0;
      end else begin
        if (!RDN) begin
          checks++;
          if (CSN !== 1'b0) begin
            errors++; $display("FAIL rdn_needs_csn: CSN=%b while RDN low, required 0", CSN);
          end
        end
        if (!RDN && rdn_q) begin
          checks++;
          last_rd_addr = addr;
          if (csn_run != RD_SETUP) begin
            errors++; $display("FAIL setup_len: got %0d clocks, required %0d", csn_run, RD_SETUP);
          end
        end
        if (RDN && !rdn_q) begin
          checks++;
          if (rdn_run != RD_LOW) begin
            errors++; $display("FAIL rdn_low_len: got %0d clocks, required %0d", rdn_run, RD_LOW);
          end
        end
        csn_run = CSN ? 0 : csn_run + 1;
        rdn_run = RDN ? 0 : rdn_run + 1;
        rdn_q   = RDN;
        if (res_valid) begin
          checks++;
          if (CSN !== 1'b1 || RDN !== 1'b1) begin
            errors++; $display("FAIL bus_during_out: CSN=%b RDN=%b, required 1 1", CSN, RDN);
          end
        end
        if (done) begin
          done_cnt++;
          checks++;
          if (done_q) begin
            errors++; $display("FAIL done_width: done high 2 clocks in a row, required 1");
          end
        end
        done_q = done;
        if (res_valid && res_ready) begin
          res_cnt++;
          checks++;
          if (sb.size() == 0) begin
            errors++; $display("FAIL unexpected_result: got fifo=%0d data=%h, required none", res_fifo, res_data);
          end else begin
            e  = sb.pop_front();
            ea = e.fifo ? TDC_ADDR_FIFO2 : TDC_ADDR_FIFO1;
            if (res_fifo !== e.fifo || res_data !== e.data || last_rd_addr !== ea) begin
              errors++;
              $display("FAIL result: got fifo=%0d data=%h addr=%0d, required fifo=%0d data=%h addr=%0d",
                       res_fifo, res_data, last_rd_addr, e.fifo, e.data, ea);
            end
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s_done_timeout: no done within %0d clocks, required a pulse", tag, bound);
    end
  endtask

  task automatic push_word(input logic fifo, input logic [TDC_DATA_W-1:0] w, input bit expect_it);
    tdc_result_t e;
    if (fifo) chip2.push_back(w); else chip1.push_back(w);
    e.fifo = fifo; e.data = w;
    if (expect_it) sb.push_back(e);
  endtask

  task automatic check_drained(input string tag, input int got, input int exp_n);
    checks++;
    if (got != exp_n || sb.size() != 0) begin
      errors++; $display("FAIL %s_count: got %0d results (%0d pending), required %0d (0 pending)",
                         tag, got, sb.size(), exp_n);
    end
  endtask

  task automatic test_reset();
    logic [45:0] got, exp_v;
    reset_n = 1'b0; start = 1'b0; init_done = 1'b0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_v = {1'b1, 1'b1, 4'd0, 4'b1111, 1'b0, 28'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      got = {CSN, RDN, addr, StopDis, res_valid, res_data, res_fifo, busy, done, hit_ovf};
      checks++;
      if (got !== exp_v) begin
        errors++; $display("FAIL reset_idle cycle %0d: got %h, required %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_window(input string tag);
    int low = 0, since_end = -1, done_at = -1, d0 = done_cnt;
    bit csn_fell = 0, bad_stop = 0;
    init_done = 1'b1; res_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < WINDOW_CYC + 100 && done_at < 0; i++) begin
      @(negedge clk);
      if (!CSN) csn_fell = 1;
      if (StopDis === 4'b0000) low++;
      else if (StopDis !== 4'b1111) bad_stop = 1;
      else if (low > 0) since_end++;
      if (done === 1'b1) done_at = since_end;
    end
    checks++;
    if (low != WINDOW_CYC || bad_stop) begin
      errors++; $display("FAIL %s_window: StopDis low %0d clocks (bad=%0d), required %0d", tag, low, bad_stop, WINDOW_CYC);
    end
    checks++;
    if (done_at != 2) begin
      errors++; $display("FAIL %s_done_delay: done %0d clocks after window, required 2", tag, done_at);
    end
    checks++;
    if (csn_fell || done_cnt != d0 + 1) begin
      errors++; $display("FAIL %s_no_access: csn_fell=%0d done_pulses=%0d, required 0 and 1", tag, csn_fell, done_cnt - d0);
    end
  endtask

  task automatic test_fifo1_reads();
    int r0 = res_cnt;
    push_word(1'b0, 28'h0000123, 1);
    push_word(1'b0, 28'h0ABCDEF, 1);
    push_word(1'b0, 28'hFFFFFFF, 1);
    res_ready = 1'b1;
    pulse_start();
    wait_done(WINDOW_CYC + 200, "fifo1");
    check_drained("fifo1", res_cnt - r0, 3);
  endtask

  task automatic test_both_fifos();
    int r0 = res_cnt;
    push_word(1'b1, 28'h2000001, 1'b0);
    push_word(1'b1, 28'h2000002, 1'b0);
    push_word(1'b0, 28'h1000001, 1);
    push_word(1'b0, 28'h1000002, 1);
    push_word(1'b1, 28'h2000001, 1'b0);
    sb.push_back('{fifo: 1'b1, data: 28'h2000001});
    sb.push_back('{fifo: 1'b1, data: 28'h2000002});
    chip2.delete();
    chip2.push_back(28'h2000001);
    chip2.push_back(28'h2000002);
    res_ready = 1'b1;
    pulse_start();
    wait_done(WINDOW_CYC + 200, "both");
    check_drained("both", res_cnt - r0, 4);
  endtask

  task automatic test_stall();
    int r0 = res_cnt;
    bit seen = 0;
    logic [TDC_DATA_W-1:0] held;
    push_word(1'b0, 28'h5A5A5A5, 1);
    push_word(1'b0, 28'h0C0FFEE, 1);
    res_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < WINDOW_CYC + 100 && !seen; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) seen = 1;
    end
    held = res_data;
    checks++;
    if (!seen || held !== 28'h5A5A5A5) begin
      errors++; $display("FAIL stall_first: valid=%0d data=%h, required 1 5a5a5a5", seen, held);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== held || CSN !== 1'b1 || RDN !== 1'b1) begin
        errors++; $display("FAIL stall_hold cycle %0d: valid=%b data=%h CSN=%b RDN=%b, required 1 %h 1 1",
                           i, res_valid, res_data, CSN, RDN, held);
      end
    end
    @(posedge clk); #1 res_ready = 1'b1;
    wait_done(200, "stall");
    check_drained("stall", res_cnt - r0, 2);
  endtask

  task automatic test_hit_ovf();
    int r0 = res_cnt;
    for (int i = 0; i < MAX_HITS + 4; i++) push_word(1'b0, 28'h0100000 + 28'(i), i < MAX_HITS);
    res_ready = 1'b1;
    pulse_start();
    wait_done(WINDOW_CYC + 400, "ovf");
    check_drained("ovf", res_cnt - r0, MAX_HITS);
    checks++;
    if (hit_ovf !== 1'b1 || chip1.size() != 4) begin
      errors++; $display("FAIL ovf_flag: hit_ovf=%b left=%0d, required 1 and 4", hit_ovf, chip1.size());
    end
    chip1.delete();
  endtask

  task automatic test_start_no_init();
    init_done = 1'b0;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || StopDis !== 4'b1111 || hit_ovf !== 1'b1) begin
        errors++; $display("FAIL no_init: busy=%b StopDis=%b hit_ovf=%b, required 0 1111 1", busy, StopDis, hit_ovf);
      end
    end
    @(posedge clk); #1 init_done = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL start_latched: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_ovf_clear();
    init_done = 1'b1;
    pulse_start();
    @(negedge clk);
    checks++;
    if (hit_ovf !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL ovf_clear: hit_ovf=%b busy=%b, required 0 1", hit_ovf, busy);
    end
    wait_done(WINDOW_CYC + 100, "ovf_clear");
  endtask

  task automatic test_reset_strobe();
    int d0;
    bit seen = 0;
    push_word(1'b0, 28'h7777777, 1'b0);
    res_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < WINDOW_CYC + 100 && !seen; i++) begin
      @(negedge clk);
      if (RDN === 1'b0) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rst_strobe_reach: RDN never fell, required a strobe");
    end
    #1 reset_n = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    checks++;
    if (CSN !== 1'b1 || RDN !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || StopDis !== 4'b1111) begin
      errors++; $display("FAIL rst_strobe: CSN=%b RDN=%b busy=%b valid=%b StopDis=%b, required 1 1 0 0 1111",
                         CSN, RDN, busy, res_valid, StopDis);
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_no_done: done pulses=%0d busy=%b, required 0 0", done_cnt - d0, busy);
    end
    chip1.delete();
  endtask

  initial begin
    test_reset();
    test_window("window");
    test_fifo1_reads();
    test_both_fifos();
    test_stall();
    test_hit_ovf();
    test_start_no_init();
    test_ovf_clear();
    test_reset_strobe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_readout_ctrl.md
Name: tdc_readout_ctrl

Overview:
- Sequences one measurement cycle on the TDC chip bus once the chip configuration sequence has finished.
- Arms the stop inputs for a fixed window, then disables them.
- Drains both chip output FIFOs through register reads and hands each 28-bit result to the downstream logic over a valid/ready interface.
- Sits between the configuration block (which provides init_done) and the result-packing logic.

Parameters:
- WINDOW_CYC, 1000: clocks the stop inputs stay enabled per measurement.
- RD_SETUP, 1: clocks from CSN/addr valid to RDN falling.
- RD_LOW, 2: clocks RDN is held low; data is sampled on the last low clock.
- MAX_HITS, 16: result cap per measurement; reaching it ends the drain.
- ADDR_FIFO1, 4'd8: register address of FIFO1.
- ADDR_FIFO2, 4'd9: register address of FIFO2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- init_done  in  1  chip configuration complete; level.
- start  in  1  one-clock request to run one measurement.
- EF1  in  1  FIFO1 empty flag from chip, active-high.
- EF2  in  1  FIFO2 empty flag from chip, active-high.
- data_in  in  28  chip data bus, read direction.
- CSN  out  1  chip select, active-low.
- RDN  out  1  read strobe, active-low.
- addr  out  4  register address.
- StopDis  out  4  stop disable [3:0] (StopDis1..4), 1 = disabled.
- res_data  out  28  result word.
- res_fifo  out  1  0 = FIFO1, 1 = FIFO2.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-clock pulse at end of measurement.
- hit_ovf  out  1  MAX_HITS reached; held until the next start.

Behaviour:
- Reset values, applied on the clk edge with reset_n = 0:
  - CSN = 1, RDN = 1, addr = 0, StopDis = 4'b1111.
  - res_valid = 0, res_data = 0, res_fifo = 0.
  - busy = 0, done = 0, hit_ovf = 0.
  - All counters are 0; state = IDLE.
- IDLE: on start & init_done, go to ARM, clear hit_ovf and the hit counter. start without init_done is ignored and not latched.
- ARM:
  - StopDis = 0000 from the first ARM clock.
  - The window counter counts 0..WINDOW_CYC-1; at the terminal count go to DISABLE.
- DISABLE: StopDis = 1111 for exactly 1 clock, then POLL. This clock lets late hits settle.
- POLL, priority FIFO1 over FIFO2:
  - If !EF1, select FIFO1 and go to SETUP.
  - Else if !EF2, select FIFO2 and go to SETUP.
  - Else go to DONE.
  - EF flags are sampled only in POLL.
- SETUP: CSN = 0 and addr = the selected FIFO address, held RD_SETUP clocks; then STROBE.
- STROBE:
  - RDN = 0 for RD_LOW clocks, with CSN and addr held.
  - data_in is registered into res_data on the last low clock.
  - Then HOLD.
- HOLD: RDN = 1 and CSN = 1 for 1 clock; addr holds its value. Increment the hit counter, then go to OUT.
- OUT:
  - res_valid = 1; res_data and res_fifo are stable while valid.
  - On res_valid & res_ready, clear valid next clock.
  - If the hit counter == MAX_HITS, set hit_ovf and go to DONE; else go to POLL.
  - res_valid & !res_ready stalls indefinitely; no chip access occurs during the stall.
- DONE: done = 1 for one clock, then IDLE.
- Minimum read cost is RD_SETUP + RD_LOW + 1 clocks, plus the handshake.
- init_done falling mid-operation: ignored; the measurement completes.
- start while busy: ignored.
- reset_n low in any state: outputs return to reset values on that edge. A pending result is discarded and no done pulse is issued.
- CSN and RDN are never low in IDLE, ARM, DISABLE, POLL, OUT or DONE.
- RDN is never low unless CSN is low.
- Hit counter width is $clog2(MAX_HITS+1); it is never compared beyond MAX_HITS.

Decomposition:
- Shared package tdc_pkg holds:
  - the state enum;
  - TDC_DATA_W = 28 and TDC_ADDR_W = 4;
  - register address constants 8 and 9, also used by the configuration block.
- One sub-module, tdc_bus_read: executes a single SETUP/STROBE/HOLD read cycle.
  - Inputs: req, sel.
  - Outputs: CSN, RDN, addr, rdata, ack.
  - It is reused later by the configuration block for readback.

Test Plan:
- Reset, then release with no start → all outputs at reset values, and StopDis = 1111 for 100 clocks.
- init_done = 1, start, EF1 = EF2 = 1 → StopDis = 0000 for exactly 1000 clocks; done pulses 2 clocks after the window ends; CSN never falls.
- EF1 goes empty after 3 reads, data 28'h0000123, 28'h0ABCDEF, 28'hFFFFFFF; res_ready held 1 → 3 results with res_fifo = 0 in order. RDN is low 2 clocks per read, 1 setup clock precedes each RDN fall, then done.
- Both FIFOs non-empty (2 words each) → the FIFO1 words come out first, then FIFO2 words with res_fifo = 1, addr 8 then 9; 4 results total.
- res_ready held 0 for 50 clocks on the first result → res_valid and res_data stable, CSN/RDN high throughout the stall; the remaining reads resume after acceptance.
- EF1 stuck 0 → exactly 16 reads, hit_ovf = 1, done pulse. Second test: start without init_done → stays IDLE. Third test: reset_n low during STROBE → CSN = RDN = 1 on the next edge, no done pulse.
